// File: rtl/rv32i_return_stack.sv
// rv32i_return_stack
// Return-address stack (RAS) fed by the push/pop strobes that the rv32i
// control stage raises on JAL/JALR when the link register is x1/x5. The
// stack is a circular buffer: when it is full, a push overwrites the oldest
// entry. The current top is offered to the fetch stage as the predicted
// return address.
//
// Parameters:
//   XLEN      address width
//   DEPTH     number of entries (power of two, >= 2)
//   PTR_BITS  log2(DEPTH)
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   reset_i      asynchronous active-high reset
//   push_i       push strobe
//   pop_i        pop strobe
//   push_addr_i  link address to push
//   flush_i      synchronous clear of the stack (highest priority)
//   top_o        predicted return address, 0 when the stack is empty
//   top_valid_o  stack is non-empty
//   count_o      occupancy, 0..DEPTH
//   overflow_o   one-cycle pulse: a push discarded the oldest entry
//   underflow_o  one-cycle pulse: a pop was issued on an empty stack
//
// Optional feature (macro RV32I_RAS_CHECKPOINT_EN):
//   checkpoint_i  save the post-operation {tp,count} of this edge
//   restore_i     reload {tp,count} from the shadow (below flush, above push/pop)
//   Entry data is not checkpointed.

module rv32i_return_stack #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 8,
  parameter int PTR_BITS = 3
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic [XLEN-1:0]     push_addr_i,
  input  logic                flush_i,
`ifdef RV32I_RAS_CHECKPOINT_EN
  input  logic                checkpoint_i,
  input  logic                restore_i,
`endif
  output logic [XLEN-1:0]     top_o,
  output logic                top_valid_o,
  output logic [PTR_BITS:0]   count_o,
  output logic                overflow_o,
  output logic                underflow_o
);

  localparam logic [PTR_BITS:0]   FULL_COUNT = (PTR_BITS+1)'(DEPTH);
  localparam logic [PTR_BITS-1:0] PTR_ONE    = PTR_BITS'(1);
  localparam logic [PTR_BITS:0]   CNT_ONE    = (PTR_BITS+1)'(1);

  logic [XLEN-1:0]     mem [DEPTH];
  logic [PTR_BITS-1:0] tp, tp_nxt;
  logic [PTR_BITS:0]   count, count_nxt;
  logic                overflow_nxt, underflow_nxt;
  logic                wr_en;
  logic [PTR_BITS-1:0] wr_idx;

`ifdef RV32I_RAS_CHECKPOINT_EN
  logic [PTR_BITS-1:0] shadow_tp;
  logic [PTR_BITS:0]   shadow_count;
`endif

  // Next-state decode. flush wins over everything; push+pop on a non-empty
  // stack replaces the top in place (coroutine swap) instead of moving tp.
  always_comb begin
    tp_nxt        = tp;
    count_nxt     = count;
    overflow_nxt  = 1'b0;
    underflow_nxt = 1'b0;
    wr_en         = 1'b0;
    wr_idx        = tp;
    if (flush_i) begin
      tp_nxt    = '0;
      count_nxt = '0;
    end
`ifdef RV32I_RAS_CHECKPOINT_EN
    else if (restore_i) begin
      tp_nxt    = shadow_tp;
      count_nxt = shadow_count;
    end
`endif
    else begin
      unique case ({push_i, pop_i})
        2'b10: begin
          tp_nxt = tp + PTR_ONE;
          wr_en  = 1'b1;
          wr_idx = tp + PTR_ONE;
          if (count == FULL_COUNT) overflow_nxt = 1'b1;
          else                     count_nxt    = count + CNT_ONE;
        end
        2'b01: begin
          if (count != '0) begin
            tp_nxt    = tp - PTR_ONE;
            count_nxt = count - CNT_ONE;
          end else begin
            underflow_nxt = 1'b1;
          end
        end
        2'b11: begin
          wr_en = 1'b1;
          if (count != '0) begin
            wr_idx = tp;
          end else begin
            // Empty stack: a swap degenerates into a plain push.
            tp_nxt    = tp + PTR_ONE;
            wr_idx    = tp + PTR_ONE;
            count_nxt = CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Pointer, occupancy and event pulses.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tp          <= '0;
      count       <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      tp          <= tp_nxt;
      count       <= count_nxt;
      overflow_o  <= overflow_nxt;
      underflow_o <= underflow_nxt;
    end
  end

  // Entry storage is never cleared; the outputs are gated by count instead.
  // A push coinciding with reset is dropped.
  always_ff @(posedge clk_i) begin
    if (wr_en && !reset_i) mem[wr_idx] <= push_addr_i;
  end

`ifdef RV32I_RAS_CHECKPOINT_EN
  // Shadow captures the state this edge produces, so a checkpoint taken
  // together with a push includes that push.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      shadow_tp    <= '0;
      shadow_count <= '0;
    end else if (checkpoint_i) begin
      shadow_tp    <= tp_nxt;
      shadow_count <= count_nxt;
    end
  end
`endif

  assign top_valid_o = (count != '0);
  assign top_o       = top_valid_o ? mem[tp] : '0;
  assign count_o     = count;

endmodule
